// File: rtl/net_endpoint_adapter_pkg.sv
// Shared ring-network definitions: default field widths, message layout
// helpers and the occupancy encoding used by the adapter's 2-entry queues.
package net_endpoint_adapter_pkg;

  localparam int unsigned NET_PAYLOAD_NBITS = 32;
  localparam int unsigned NET_OPAQUE_NBITS  = 3;
  localparam int unsigned NET_SRCDEST_NBITS = 3;

  // Message layout, MSB to LSB: {dest, src, opaque, payload}
  function automatic int unsigned net_msg_nbits(input int unsigned p,
                                                input int unsigned o,
                                                input int unsigned s);
    return p + o + 2 * s;
  endfunction

  function automatic int unsigned net_opaque_lsb(input int unsigned p);
    return p;
  endfunction

  function automatic int unsigned net_src_lsb(input int unsigned p,
                                              input int unsigned o);
    return p + o;
  endfunction

  function automatic int unsigned net_dest_lsb(input int unsigned p,
                                               input int unsigned o,
                                               input int unsigned s);
    return p + o + s;
  endfunction

  localparam int unsigned VC_NET_MSG_NBITS =
    net_msg_nbits(NET_PAYLOAD_NBITS, NET_OPAQUE_NBITS, NET_SRCDEST_NBITS);

  // Occupancy of a 2-entry queue; entry 0 is always the head.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

endpackage

// File: rtl/net_endpoint_adapter_if.sv
// Core-side and ring-side handshakes of one endpoint adapter, plus its
// status outputs. The slave modport is the adapter's view.
interface net_endpoint_adapter_if
  import net_endpoint_adapter_pkg::*;
#(
  parameter int unsigned p_payload_nbits = NET_PAYLOAD_NBITS,
  parameter int unsigned p_opaque_nbits  = NET_OPAQUE_NBITS,
  parameter int unsigned p_srcdest_nbits = NET_SRCDEST_NBITS
) ();

  localparam int unsigned M =
    net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);

  logic                       req_val;
  logic                       req_rdy;
  logic [p_srcdest_nbits-1:0] req_dest;
  logic [p_payload_nbits-1:0] req_payload;

  logic                       net_in_val;
  logic                       net_in_rdy;
  logic [M-1:0]               net_in_msg;

  logic                       net_out_val;
  logic                       net_out_rdy;
  logic [M-1:0]               net_out_msg;

  logic                       resp_val;
  logic                       resp_rdy;
  logic [p_srcdest_nbits-1:0] resp_src;
  logic [p_opaque_nbits-1:0]  resp_tag;
  logic [p_payload_nbits-1:0] resp_payload;

  logic [p_opaque_nbits:0]    outstanding;
  logic                       err_misroute;
  logic                       err_badtag;

  modport master (
    output req_val, req_dest, req_payload, net_in_rdy, net_out_val,
           net_out_msg, resp_rdy,
    input  req_rdy, net_in_val, net_in_msg, net_out_rdy, resp_val,
           resp_src, resp_tag, resp_payload, outstanding, err_misroute,
           err_badtag
  );

  modport slave (
    input  req_val, req_dest, req_payload, net_in_rdy, net_out_val,
           net_out_msg, resp_rdy,
    output req_rdy, net_in_val, net_in_msg, net_out_rdy, resp_val,
           resp_src, resp_tag, resp_payload, outstanding, err_misroute,
           err_badtag
  );

endinterface

// File: rtl/net_endpoint_adapter_tag_alloc.sv
// Opaque tag pool: busy vector, lowest-free picker and in-use counter.
// Allocation looks only at the registered busy vector, so a tag freed this
// cycle becomes allocatable next cycle and can never collide with the tag
// being allocated.
module net_endpoint_adapter_tag_alloc
  import net_endpoint_adapter_pkg::*;
#(
  parameter int unsigned p_opaque_nbits = NET_OPAQUE_NBITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            alloc_i,
  input  logic                            free_i,
  input  logic [p_opaque_nbits-1:0]       free_tag_i,
  output logic [(1<<p_opaque_nbits)-1:0]  busy_o,
  output logic                            any_free_o,
  output logic [p_opaque_nbits-1:0]       alloc_tag_o,
  output logic [p_opaque_nbits:0]         outstanding_o
);

  localparam int unsigned O = p_opaque_nbits;
  localparam int unsigned T = 1 << O;
  localparam logic [O:0]  T_CNT   = {1'b1, {O{1'b0}}};
  localparam logic [O:0]  ONE_CNT = {{O{1'b0}}, 1'b1};

  logic [T-1:0] busy_q, busy_d;
  logic [O:0]   cnt_q, cnt_d;

  assign busy_o        = busy_q;
  assign outstanding_o = cnt_q;

  // Lowest-index free tag; scanning downward lets the lowest win.
  always_comb begin
    alloc_tag_o = '0;
    any_free_o  = 1'b0;
    for (int i = T - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_tag_o = O'(i);
        any_free_o  = 1'b1;
      end
    end
  end

  // Next busy vector and counter; alloc and free never name the same tag.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (alloc_i) busy_d[alloc_tag_o] = 1'b1;
    if (free_i)  busy_d[free_tag_i]  = 1'b0;
    case ({alloc_i, free_i})
      2'b10:   cnt_d = cnt_q + ONE_CNT;
      2'b01:   cnt_d = cnt_q - ONE_CNT;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pool state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Counter must stay in 0..T and never step past either end.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (cnt_q <= T_CNT);
      assert (!(free_i && !alloc_i && (cnt_q == '0)));
      assert (!(alloc_i && !free_i && (cnt_q == T_CNT)));
    end
  end

endmodule

// File: rtl/net_endpoint_adapter.sv
// Endpoint adapter for one ring port: wraps core requests into tagged
// network messages, retires tags on matching responses and returns them to
// the core. Misrouted or unexpected-tag messages are dropped and flagged.
module net_endpoint_adapter
  import net_endpoint_adapter_pkg::*;
#(
  parameter int unsigned p_payload_nbits = NET_PAYLOAD_NBITS,
  parameter int unsigned p_opaque_nbits  = NET_OPAQUE_NBITS,
  parameter int unsigned p_srcdest_nbits = NET_SRCDEST_NBITS,
  parameter int unsigned p_endpoint_id   = 0
) (
  input  logic                  clk,
  input  logic                  reset,   // active-low, asynchronous
  net_endpoint_adapter_if.slave bus
);

  localparam int unsigned P       = p_payload_nbits;
  localparam int unsigned O       = p_opaque_nbits;
  localparam int unsigned S       = p_srcdest_nbits;
  localparam int unsigned T       = 1 << O;
  localparam int unsigned M       = net_msg_nbits(P, O, S);
  localparam int unsigned OPQ_LSB = net_opaque_lsb(P);
  localparam int unsigned SRC_LSB = net_src_lsb(P, O);
  localparam int unsigned DST_LSB = net_dest_lsb(P, O, S);
  localparam int unsigned RW      = S + O + P;
  localparam logic [S-1:0] MY_ID  = p_endpoint_id[S-1:0];

  logic         any_free;
  logic [O-1:0] alloc_tag;
  logic [T-1:0] busy;

  logic         req_rdy_w, req_fire;
  logic [M-1:0] req_msg;

  logic         net_out_rdy_w, out_fire;
  logic [S-1:0] rx_dest, rx_src;
  logic [O-1:0] rx_tag;
  logic [P-1:0] rx_payload;
  logic         rx_mis, rx_bad, rx_ok;

  q_state_e     inj_state_q, inj_state_d;
  logic [M-1:0] inj_ent0_q, inj_ent1_q;
  logic         inj_wr0, inj_wr1, inj_shift, inj_deq;

  q_state_e      rsp_state_q, rsp_state_d;
  logic [RW-1:0] rsp_ent0_q, rsp_ent1_q, rsp_in;
  logic          rsp_wr0, rsp_wr1, rsp_shift, rsp_deq, rsp_enq;

  logic err_mis_q, err_bad_q;

  // ---- request path ----
  // Held low during reset even though the pool looks empty then.
  assign req_rdy_w   = reset && any_free && (inj_state_q != Q_FULL);
  assign req_fire    = bus.req_val && req_rdy_w;
  assign req_msg     = {bus.req_dest, MY_ID, alloc_tag, bus.req_payload};
  assign bus.req_rdy = req_rdy_w;

  assign inj_deq        = (inj_state_q != Q_EMPTY) && bus.net_in_rdy;
  assign bus.net_in_val = (inj_state_q != Q_EMPTY);
  assign bus.net_in_msg = inj_ent0_q;

  // ---- receive path ----
  assign rx_dest    = bus.net_out_msg[DST_LSB +: S];
  assign rx_src     = bus.net_out_msg[SRC_LSB +: S];
  assign rx_tag     = bus.net_out_msg[OPQ_LSB +: O];
  assign rx_payload = bus.net_out_msg[P-1:0];
  assign rx_mis     = (rx_dest != MY_ID);
  assign rx_bad     = !busy[rx_tag];
  assign rx_ok      = !rx_mis && !rx_bad;

  assign net_out_rdy_w   = (rsp_state_q != Q_FULL);
  assign out_fire        = bus.net_out_val && net_out_rdy_w;
  assign bus.net_out_rdy = net_out_rdy_w;

  assign rsp_enq = out_fire && rx_ok;
  assign rsp_in  = {rx_src, rx_tag, rx_payload};
  assign rsp_deq = (rsp_state_q != Q_EMPTY) && bus.resp_rdy;

  assign bus.resp_val     = (rsp_state_q != Q_EMPTY);
  assign bus.resp_src     = rsp_ent0_q[RW-1 -: S];
  assign bus.resp_tag     = rsp_ent0_q[P +: O];
  assign bus.resp_payload = rsp_ent0_q[P-1:0];

  assign bus.err_misroute = err_mis_q;
  assign bus.err_badtag   = err_bad_q;

  net_endpoint_adapter_tag_alloc #(
    .p_opaque_nbits (O)
  ) u_tags (
    .clk           (clk),
    .reset         (reset),
    .alloc_i       (req_fire),
    .free_i        (rsp_enq),
    .free_tag_i    (rx_tag),
    .busy_o        (busy),
    .any_free_o    (any_free),
    .alloc_tag_o   (alloc_tag),
    .outstanding_o (bus.outstanding)
  );

  // Inject queue occupancy and write steering; full rejects via req_rdy.
  always_comb begin
    inj_state_d = inj_state_q;
    inj_wr0     = 1'b0;
    inj_wr1     = 1'b0;
    inj_shift   = 1'b0;
    case (inj_state_q)
      Q_EMPTY: if (req_fire) begin
        inj_wr0     = 1'b1;
        inj_state_d = Q_ONE;
      end
      Q_ONE: begin
        if (req_fire && inj_deq) begin
          inj_wr0 = 1'b1;
        end else if (req_fire) begin
          inj_wr1     = 1'b1;
          inj_state_d = Q_FULL;
        end else if (inj_deq) begin
          inj_state_d = Q_EMPTY;
        end
      end
      Q_FULL: if (inj_deq) begin
        inj_shift   = 1'b1;
        inj_state_d = Q_ONE;
      end
      default: inj_state_d = Q_EMPTY;
    endcase
  end

  // Response queue occupancy and write steering; full rejects via net_out_rdy.
  always_comb begin
    rsp_state_d = rsp_state_q;
    rsp_wr0     = 1'b0;
    rsp_wr1     = 1'b0;
    rsp_shift   = 1'b0;
    case (rsp_state_q)
      Q_EMPTY: if (rsp_enq) begin
        rsp_wr0     = 1'b1;
        rsp_state_d = Q_ONE;
      end
      Q_ONE: begin
        if (rsp_enq && rsp_deq) begin
          rsp_wr0 = 1'b1;
        end else if (rsp_enq) begin
          rsp_wr1     = 1'b1;
          rsp_state_d = Q_FULL;
        end else if (rsp_deq) begin
          rsp_state_d = Q_EMPTY;
        end
      end
      Q_FULL: if (rsp_deq) begin
        rsp_shift   = 1'b1;
        rsp_state_d = Q_ONE;
      end
      default: rsp_state_d = Q_EMPTY;
    endcase
  end

  // Control state: queue occupancies and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_state_q <= Q_EMPTY;
      rsp_state_q <= Q_EMPTY;
      err_mis_q   <= 1'b0;
      err_bad_q   <= 1'b0;
    end else begin
      inj_state_q <= inj_state_d;
      rsp_state_q <= rsp_state_d;
      if (out_fire && rx_mis) err_mis_q <= 1'b1;
      if (out_fire && rx_bad) err_bad_q <= 1'b1;
    end
  end

  // Queue storage; contents are qualified by occupancy, so no reset needed.
  always_ff @(posedge clk) begin
    if (inj_wr0)        inj_ent0_q <= req_msg;
    else if (inj_shift) inj_ent0_q <= inj_ent1_q;
    if (inj_wr1)        inj_ent1_q <= req_msg;
    if (rsp_wr0)        rsp_ent0_q <= rsp_in;
    else if (rsp_shift) rsp_ent0_q <= rsp_ent1_q;
    if (rsp_wr1)        rsp_ent1_q <= rsp_in;
  end

endmodule

// File: tb/tb_net_endpoint_adapter.sv
// Bench for net_endpoint_adapter at endpoint id 2: directed scenarios then a
// randomized loopback run, all cross-checked every cycle against a
// transaction-level model (tag set, message queues, sticky flags).
module tb_net_endpoint_adapter;
  import net_endpoint_adapter_pkg::*;

  localparam int P = 32;
  localparam int O = 3;
  localparam int S = 3;
  localparam int M = VC_NET_MSG_NBITS;
  localparam logic [2:0] ID = 3'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  net_endpoint_adapter_if #(.p_payload_nbits(P), .p_opaque_nbits(O),
                            .p_srcdest_nbits(S)) bus ();

  net_endpoint_adapter #(
    .p_payload_nbits (P),
    .p_opaque_nbits  (O),
    .p_srcdest_nbits (S),
    .p_endpoint_id   (2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit           m_run = 0;
  bit           m_busy [8];
  logic [M-1:0] m_inj [$];
  logic [37:0]  m_resp [$];
  bit           m_mis, m_bad;

  bit           step_out_fire, step_pop_valid;
  logic [M-1:0] step_pop_msg;
  logic [M-1:0] net_pend [$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_lowest();
    for (int i = 0; i < 8; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_busy[i] = 0;
    m_inj.delete();
    m_resp.delete();
    m_mis = 0;
    m_bad = 0;
  endtask

  // Check every output against the model, then advance model and clock.
  task automatic step();
    int low;
    bit e_rr, do_req, do_pop, do_out, do_rpop;
    bit busy_s [8];
    logic [M-1:0] msg;
    logic [37:0]  rh;
    logic [2:0]   t, dest, src;
    #1;
    low  = m_lowest();
    e_rr = m_run && (low >= 0) && (m_inj.size() < 2);
    check("req_rdy", bus.req_rdy, 64'(e_rr));
    check("net_in_val", bus.net_in_val, 64'(m_inj.size() > 0));
    if (m_inj.size() > 0) check("net_in_msg", bus.net_in_msg, m_inj[0]);
    check("net_out_rdy", bus.net_out_rdy, 64'(m_resp.size() < 2));
    check("resp_val", bus.resp_val, 64'(m_resp.size() > 0));
    if (m_resp.size() > 0) begin
      rh = m_resp[0];
      check("resp_src", bus.resp_src, rh[37:35]);
      check("resp_tag", bus.resp_tag, rh[34:32]);
      check("resp_payload", bus.resp_payload, rh[31:0]);
    end
    check("outstanding", bus.outstanding, 64'(m_count()));
    check("err_misroute", bus.err_misroute, 64'(m_mis));
    check("err_badtag", bus.err_badtag, 64'(m_bad));
    step_out_fire  = 0;
    step_pop_valid = 0;
    if (m_run) begin
      busy_s  = m_busy;
      do_req  = bus.req_val && e_rr;
      do_pop  = (m_inj.size() > 0) && bus.net_in_rdy;
      do_out  = bus.net_out_val && (m_resp.size() < 2);
      do_rpop = (m_resp.size() > 0) && bus.resp_rdy;
      if (do_pop) begin
        step_pop_msg   = m_inj.pop_front();
        step_pop_valid = 1;
      end
      if (do_req) begin
        t = 3'(low);
        m_inj.push_back({bus.req_dest, ID, t, bus.req_payload});
        m_busy[low] = 1;
      end
      if (do_rpop) void'(m_resp.pop_front());
      if (do_out) begin
        msg  = bus.net_out_msg;
        dest = msg[40:38];
        src  = msg[37:35];
        t    = msg[34:32];
        step_out_fire = 1;
        if (dest != ID) m_mis = 1;
        if (!busy_s[t]) m_bad = 1;
        if (dest == ID && busy_s[t]) begin
          m_busy[t] = 0;
          m_resp.push_back({src, t, msg[31:0]});
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_req(input logic [2:0] d, input logic [31:0] p);
    bus.req_val     = 1'b1;
    bus.req_dest    = d;
    bus.req_payload = p;
    step();
    bus.req_val = 1'b0;
  endtask

  // Present a message until the model says it was accepted (bounded).
  task automatic send_net(input logic [M-1:0] msg);
    bit done = 0;
    bus.net_out_val = 1'b1;
    bus.net_out_msg = msg;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = step_out_fire;
    end
    bus.net_out_val = 1'b0;
    check("net_out_accept", 64'(done), 64'd1);
  endtask

  // Return one pending network message as a response, at random.
  task automatic maybe_loopback();
    int idx;
    logic [M-1:0] mm;
    if (!bus.net_out_val && net_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      idx = $urandom_range(0, net_pend.size() - 1);
      mm  = net_pend[idx];
      net_pend.delete(idx);
      bus.net_out_msg = {ID, mm[40:38], mm[34:32], 32'($urandom)};
      bus.net_out_val = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] v;
    int guard;
    bus.req_val = 0; bus.req_dest = 0; bus.req_payload = 0;
    bus.net_in_rdy = 1; bus.net_out_val = 0; bus.net_out_msg = '0;
    bus.resp_rdy = 1;
    m_reset();

    // Reset state
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    m_run = 1;
    step();

    // Single transaction
    do_req(3'd5, 32'hCAFE0001);
    #1;
    check("t1_net_in_val", bus.net_in_val, 1);
    check("t1_net_in_msg", bus.net_in_msg, {3'd5, 3'd2, 3'd0, 32'hCAFE0001});
    step();
    send_net({3'd2, 3'd5, 3'd0, 32'h00001234});
    #1;
    check("t1_resp_val", bus.resp_val, 1);
    check("t1_resp_src", bus.resp_src, 5);
    check("t1_resp_tag", bus.resp_tag, 0);
    check("t1_resp_payload", bus.resp_payload, 32'h1234);
    check("t1_outstanding", bus.outstanding, 0);
    step();

    // Pool exhaustion
    bus.req_val = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.req_dest    = 3'($urandom_range(0, 7));
      bus.req_payload = $urandom;
      if (i == 8) begin
        #1;
        check("pool_full_req_rdy", bus.req_rdy, 0);
        check("pool_full_outstanding", bus.outstanding, 8);
      end
      step();
    end
    bus.req_val = 1'b0;
    step();
    send_net({ID, 3'd1, 3'd3, 32'h33});
    do_req(3'd6, 32'h0000600D);
    #1;
    v = bus.net_in_msg;
    check("reuse_tag3", v[34:32], 3);
    for (int t = 0; t < 8; t++) send_net({ID, 3'd1, 3'(t), $urandom});
    step();
    step();

    // Simultaneous allocate and free
    do_req(3'd1, 32'hA);
    do_req(3'd1, 32'hB);
    bus.req_val = 1'b1; bus.req_dest = 3'd4; bus.req_payload = 32'hC;
    bus.net_out_val = 1'b1; bus.net_out_msg = {ID, 3'd1, 3'd0, 32'hD};
    step();
    bus.req_val = 1'b0; bus.net_out_val = 1'b0;
    #1;
    v = bus.net_in_msg;
    check("simul_new_tag", v[34:32], 2);
    check("simul_outstanding", bus.outstanding, 2);
    send_net({ID, 3'd1, 3'd1, 32'hE});
    send_net({ID, 3'd4, 3'd2, 32'hF});
    step();

    // Errors
    do_req(3'd3, 32'h77);
    send_net({3'd4, 3'd5, 3'd0, 32'h44});
    #1;
    check("err_mis_set", bus.err_misroute, 1);
    check("err_mis_only", bus.err_badtag, 0);
    check("err_mis_no_resp", bus.resp_val, 0);
    send_net({ID, 3'd5, 3'd6, 32'h66});
    #1;
    check("err_bad_set", bus.err_badtag, 1);
    check("err_mis_sticky", bus.err_misroute, 1);
    for (int i = 0; i < 3; i++) step();
    send_net({ID, 3'd3, 3'd0, 32'h88});
    step();

    // Response back-pressure
    bus.resp_rdy = 1'b0;
    do_req(3'd1, 32'h100);
    do_req(3'd1, 32'h101);
    do_req(3'd1, 32'h102);
    step();
    send_net({ID, 3'd1, 3'd0, 32'h200});
    send_net({ID, 3'd1, 3'd1, 32'h201});
    bus.net_out_val = 1'b1;
    bus.net_out_msg = {ID, 3'd1, 3'd2, 32'h202};
    for (int i = 0; i < 3; i++) step();
    #1;
    check("bp_net_out_rdy", bus.net_out_rdy, 0);
    check("bp_resp_head", bus.resp_payload, 32'h200);
    bus.resp_rdy = 1'b1;
    guard = 0;
    step_out_fire = 0;
    while (!step_out_fire && guard < 10) begin
      step();
      guard++;
    end
    bus.net_out_val = 1'b0;
    check("bp_third_accepted", 64'(step_out_fire), 1);
    for (int i = 0; i < 3; i++) step();

    // Inject back-pressure, then build up state for the reset test
    bus.net_in_rdy = 1'b0;
    bus.req_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_payload = 32'h300 + 32'(i);
      step();
    end
    #1;
    check("inj_bp_req_rdy", bus.req_rdy, 0);
    bus.net_in_rdy = 1'b1;
    step();
    bus.net_in_rdy = 1'b0;
    step();
    bus.req_val = 1'b0;
    bus.resp_rdy = 1'b0;
    send_net({ID, 3'd1, 3'd0, 32'h400});
    bus.net_in_rdy = 1'b1;
    step();
    bus.net_in_rdy = 1'b0;
    do_req(3'd7, 32'h500);
    #1;
    check("pre_reset_outstanding", bus.outstanding, 3);

    // Asynchronous reset between edges
    #1;
    rst_n = 1'b0;
    m_run = 0;
    m_reset();
    #1;
    check("rst_net_in_val", bus.net_in_val, 0);
    check("rst_resp_val", bus.resp_val, 0);
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_req_rdy", bus.req_rdy, 0);
    check("rst_err_badtag", bus.err_badtag, 0);
    check("rst_err_misroute", bus.err_misroute, 0);
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    m_run = 1;
    bus.net_in_rdy = 1'b1;
    bus.resp_rdy = 1'b1;
    send_net({ID, 3'd5, 3'd1, 32'h999});
    #1;
    check("late_msg_badtag", bus.err_badtag, 1);
    check("late_msg_no_resp", bus.resp_val, 0);
    step();

    // Randomized loopback traffic
    net_pend.delete();
    for (int c = 0; c < 500; c++) begin
      bus.req_val     = 1'($urandom_range(0, 1));
      bus.req_dest    = 3'($urandom_range(0, 7));
      bus.req_payload = $urandom;
      bus.net_in_rdy  = ($urandom_range(0, 3) != 0);
      bus.resp_rdy    = ($urandom_range(0, 3) != 0);
      maybe_loopback();
      step();
      if (step_pop_valid) net_pend.push_back(step_pop_msg);
      if (step_out_fire) bus.net_out_val = 1'b0;
    end
    bus.req_val = 1'b0;
    bus.net_in_rdy = 1'b1;
    bus.resp_rdy = 1'b1;
    guard = 0;
    while ((net_pend.size() > 0 || bus.net_out_val || m_count() > 0 ||
            m_inj.size() > 0 || m_resp.size() > 0) && guard < 300) begin
      maybe_loopback();
      step();
      if (step_pop_valid) net_pend.push_back(step_pop_msg);
      if (step_out_fire) bus.net_out_val = 1'b0;
      guard++;
    end
    check("drain_in_time", 64'(guard < 300), 1);
    #1;
    check("drain_outstanding", bus.outstanding, 0);
    check("drain_resp_val", bus.resp_val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/net_endpoint_adapter.md
Name: net_endpoint_adapter

Overview:
- Terminal-side adapter for one port of the ring network. It turns core requests into network messages and drives the network's per-port input. It also accepts messages from the network's per-port output and returns them to the core as responses.
- It allocates and retires opaque tags, bounds the number of outstanding transactions, and flags misrouted or unexpected messages.
- One instance sits between each core/cache and its ring port.

Parameters:
- p_payload_nbits, 32, payload width (p)
- p_opaque_nbits, 3, opaque/tag width (o); tag pool size T = 2^o
- p_srcdest_nbits, 3, src/dest id width (s)
- p_endpoint_id, 0, this endpoint's router id, placed in the src field
- c_net_msg_nbits, p+o+2s, message width (m); layout MSB to LSB is {dest, src, opaque, payload}

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- req_val  in  1  core request valid
- req_rdy  out  1  core request ready
- req_dest  in  s  destination endpoint id
- req_payload  in  p  request payload
- net_in_val  out  1  message valid toward router in1
- net_in_rdy  in  1  router in1 ready
- net_in_msg  out  m  message toward router in1
- net_out_val  in  1  message valid from router out1
- net_out_rdy  out  1  ready to router out1
- net_out_msg  in  m  message from router out1
- resp_val  out  1  response valid to core
- resp_rdy  in  1  core response ready
- resp_src  out  s  responder id
- resp_tag  out  o  tag of the retired transaction
- resp_payload  out  p  response payload
- outstanding  out  o+1  count of tags in use
- err_misroute  out  1  sticky: message received with dest != p_endpoint_id
- err_badtag  out  1  sticky: message received with a tag not in use

Behaviour:
- Handshake: a transfer occurs when val && rdy on the same rising edge. val never depends combinationally on rdy of the same interface.
- Reset (reset=0, asynchronous):
  - all tags free; outstanding=0
  - both queues empty; net_in_val=0, resp_val=0
  - err_misroute=0, err_badtag=0
  - req_rdy=0 while reset is asserted
  - Reset mid-transaction discards all in-flight state. Late network messages arriving after reset are tagged bad.
- Tag pool: a registered T-bit busy vector.
  - Allocation picks the lowest-index free tag, using the registered vector only.
- Request path:
  - req_rdy = (some tag free) && (inject queue not full).
  - On accept: the message {req_dest, p_endpoint_id, tag, req_payload} enters a 2-entry inject queue, the tag is marked busy, and outstanding increments.
  - net_in_val rises the cycle after accept (latency 1). One request per cycle is sustained when net_in_rdy=1.
  - req_dest == p_endpoint_id is legal (self-loop).
- Receive path:
  - net_out_rdy = response queue not full (2-entry queue).
  - On accept with dest==p_endpoint_id and the tag busy: the tag is freed, outstanding decrements, and {src, tag, payload} is enqueued. resp_val rises the next cycle.
  - On accept with dest != p_endpoint_id: the message is dropped, err_misroute is set, and the tag is not freed.
  - On accept with a free tag: the message is dropped and err_badtag is set. If both errors apply, set both.
- Simultaneous allocate and free in one cycle:
  - outstanding is unchanged.
  - The freed tag is usable from the next cycle.
  - Allocating and freeing the same tag in the same cycle is impossible, because allocation sees it busy.
- Full pool: when outstanding==T, req_rdy=0 until a free occurs. req_rdy rises the cycle after the retiring accept.
- Back-pressure:
  - net_in_rdy=0 holds net_in_val/msg stable; the queue fills and then req_rdy=0.
  - resp_rdy=0 holds resp_* stable; after 2 entries net_out_rdy=0.
- Width: outstanding counts 0..T inclusive with no wrap; an assertion checks it never exceeds T and never underflows.

Decomposition:
- Shared net package:
  - message field offsets and widths (dest/src/opaque/payload slices)
  - VC_NET_MSG_NBITS
  - field pack and unpack macros, reused by the router and by this block
- Natural sub-module: net_tag_allocator, holding the busy vector, lowest-free priority encoder, free-on-retire logic, and outstanding counter.
- The two queues are existing 2-entry normal queue instances.

Test Plan:
- Single transaction (id=2):
  - Stimulus: request dest=5, payload=0xCAFE0001.
  - Required: net_in_msg={5,2,0,0xCAFE0001} one cycle later.
  - Then loop back {2,5,0,0x1234} -> resp_src=5, resp_tag=0, resp_payload=0x1234, outstanding returns 0.
- Pool exhaustion:
  - Stimulus: 9 back-to-back requests with net_in_rdy=1 and no responses.
  - Required: tags 0..7 issued in order, outstanding=8, req_rdy=0 on the 9th.
  - Retire tag 3 -> next request gets tag 3.
- Simultaneous allocate and free:
  - Stimulus: with tags 0,1 busy, a request is accepted in the same cycle as the response for tag 0.
  - Required: new tag=2, outstanding stays 2.
- Errors:
  - Stimulus: message dest=4 at id=2.
  - Required: err_misroute=1, no resp_val.
  - Stimulus: message with free tag 6.
  - Required: err_badtag=1; both errors remain set until reset.
- Back-pressure:
  - Stimulus: resp_rdy=0 with 3 incoming responses.
  - Required: 2 are accepted and net_out_rdy=0; release resp_rdy -> responses drain in order.
  - Stimulus: net_in_rdy=0.
  - Required: req_rdy=0 after 2 accepts.
- Asynchronous reset mid-operation:
  - Stimulus: assert reset between clock edges while outstanding=3 and both queues hold data.
  - Required: outputs cleared immediately; after release a response for old tag 1 sets err_badtag.
